// File: rtl/tpm_pkg.sv
// Shared widths and types for the triple-ported memory cluster front end.
package tpm_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int TAG_W     = 2;
  localparam int NUM_PORTS = 3;
  localparam int NUM_BANKS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
  } req_t;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    return tag + 1'b1;
  endfunction

endpackage

// File: rtl/tpm_request_scheduler_if.sv
// Request, cluster and response bundle between requesters, scheduler and cluster.
// The slave modport is the scheduler's view; the master modport is the environment's.
interface tpm_request_scheduler_if;

  logic [tpm_pkg::NUM_PORTS-1:0]                 req_valid;
  logic [tpm_pkg::NUM_PORTS-1:0]                 req_ready;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::ADDR_W-1:0] req_addr;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::DATA_W-1:0] req_wdata;
  logic [tpm_pkg::NUM_PORTS-1:0]                 req_wen;

  logic [tpm_pkg::NUM_PORTS-1:0]                 mem_valid;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::ADDR_W-1:0] mem_addr;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::DATA_W-1:0] mem_wdata;
  logic [tpm_pkg::NUM_PORTS-1:0]                 mem_wen;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::TAG_W-1:0]  mem_tag;
  logic                                          freeze_inputs;

  logic [tpm_pkg::NUM_PORTS-1:0]                 mem_valid_out;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::DATA_W-1:0] mem_data_out;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::TAG_W-1:0]  mem_tag_out;

  logic [tpm_pkg::NUM_PORTS-1:0]                 rsp_valid;
  logic [tpm_pkg::NUM_PORTS*tpm_pkg::DATA_W-1:0] rsp_data;
  logic [tpm_pkg::NUM_PORTS-1:0]                 tag_error;

  modport master (
    output req_valid, req_addr, req_wdata, req_wen, freeze_inputs,
           mem_valid_out, mem_data_out, mem_tag_out,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wen, mem_tag,
           rsp_valid, rsp_data, tag_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, freeze_inputs,
           mem_valid_out, mem_data_out, mem_tag_out,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wen, mem_tag,
           rsp_valid, rsp_data, tag_error
  );

endinterface

// File: rtl/tpm_req_fifo.sv
// Per-port request buffer holding {addr, wdata, wen}; DEPTH must be a power of two >= 2.
// The head reads as all zeros while the buffer is empty.
module tpm_req_fifo
  import tpm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  req_t                   push_data,
  input  logic                   pop,
  output req_t                   head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];

  req_t             store [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : store[rptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= push_data;
  end

endmodule

// File: rtl/tpm_request_scheduler.sv
// Issue controller for the memory cluster: buffering, replay under freeze, read tagging,
// outstanding-read limiting and registered responses. Macro TPM_SCHED_TAG_CHECK_EN adds tag checking.
module tpm_request_scheduler
  import tpm_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tpm_request_scheduler_if.slave bus
);

  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [2:0] MAX_OUT = MAX_OUTSTANDING[2:0];

  logic [NUM_PORTS-1:0]        ready_v;
  logic [NUM_PORTS-1:0]        mem_valid_v;
  logic [NUM_PORTS-1:0]        mem_wen_v;
  logic [NUM_PORTS*ADDR_W-1:0] mem_addr_v;
  logic [NUM_PORTS*DATA_W-1:0] mem_wdata_v;
  logic [NUM_PORTS*TAG_W-1:0]  mem_tag_v;
  logic [NUM_PORTS-1:0]        rsp_valid_v;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data_v;
  logic [NUM_PORTS-1:0]        tag_error_v;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    req_t             push_data;
    req_t             head;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             head_read;
    logic             at_limit;
    logic             port_valid;
    logic             issue;
    logic             read_issue;
    logic             resp;
    logic             resp_dec;
    logic [TAG_W-1:0] itag;
    logic [2:0]       outstanding;
    logic             rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign push_data.addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
    assign push_data.wdata = bus.req_wdata[k*DATA_W +: DATA_W];
    assign push_data.wen   = bus.req_wen[k];

    // Ready comes only from the registered count, never from freeze_inputs.
    assign ready_v[k] = (count != DEPTH_C);
    assign push       = bus.req_valid[k] & ready_v[k];

    tpm_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (issue),
      .head      (head),
      .empty     (empty),
      .count     (count)
    );

    assign head_read  = ~empty & ~head.wen;
    assign at_limit   = (outstanding == MAX_OUT);
    assign port_valid = ~empty & ~(head_read & at_limit);
    assign issue      = port_valid & ~bus.freeze_inputs;
    assign read_issue = issue & head_read;
    assign resp       = bus.mem_valid_out[k];
    assign resp_dec   = resp & (outstanding != 3'd0);

    assign mem_valid_v[k]                 = port_valid;
    assign mem_wen_v[k]                   = head.wen;
    assign mem_addr_v[k*ADDR_W +: ADDR_W] = head.addr;
    assign mem_wdata_v[k*DATA_W +: DATA_W] = head.wdata;
    assign mem_tag_v[k*TAG_W +: TAG_W]    = head_read ? itag : '0;

    // A spurious response at zero outstanding must not wrap the counter.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        itag        <= '0;
        outstanding <= '0;
        rsp_valid_q <= 1'b0;
        rsp_data_q  <= '0;
      end else begin
        if (read_issue) itag <= next_tag(itag);
        case ({read_issue, resp_dec})
          2'b10:   outstanding <= outstanding + 3'd1;
          2'b01:   outstanding <= outstanding - 3'd1;
          default: outstanding <= outstanding;
        endcase
        rsp_valid_q <= resp;
        if (resp) rsp_data_q <= bus.mem_data_out[k*DATA_W +: DATA_W];
      end
    end

    assign rsp_valid_v[k]                 = rsp_valid_q;
    assign rsp_data_v[k*DATA_W +: DATA_W] = rsp_data_q;

`ifdef TPM_SCHED_TAG_CHECK_EN
    logic [TAG_W-1:0] etag;
    logic             err;

    // Responses must come back in issue order; any out-of-order or unsolicited one latches the error.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        etag <= '0;
        err  <= 1'b0;
      end else if (resp) begin
        etag <= next_tag(etag);
        if ((bus.mem_tag_out[k*TAG_W +: TAG_W] != etag) || (outstanding == 3'd0)) err <= 1'b1;
      end
    end

    assign tag_error_v[k] = err;
`else
    assign tag_error_v[k] = 1'b0;
`endif
  end

  assign bus.req_ready = ready_v;
  assign bus.mem_valid = mem_valid_v;
  assign bus.mem_wen   = mem_wen_v;
  assign bus.mem_addr  = mem_addr_v;
  assign bus.mem_wdata = mem_wdata_v;
  assign bus.mem_tag   = mem_tag_v;
  assign bus.rsp_valid = rsp_valid_v;
  assign bus.rsp_data  = rsp_data_v;
  assign bus.tag_error = tag_error_v;

endmodule
